// File: rtl/psum_buffer.sv
// Partial-sum tile buffer between the corelet SFU and the writeback path.
// Accumulates a tile over several passes, then drains it in address order.
module psum_buffer #(
  parameter int psum_bw = 16,
  parameter int col     = 8,
  parameter int DEPTH   = 64,
  parameter int AW      = 6
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   first_pass,
  input  logic                   last_pass,
  input  logic                   psum_mem_rd,
  input  logic                   psum_mem_wr,
  input  logic [col*psum_bw-1:0] psum_mem_din,
  output logic [col*psum_bw-1:0] psum_mem_dout,
  input  logic                   out_rd,
  output logic [col*psum_bw-1:0] out_dout,
  output logic                   out_valid,
  output logic                   pass_done,
  output logic                   out_done,
  output logic                   busy,
  output logic                   err
);

  localparam int W = col * psum_bw;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ACCUM = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [W-1:0] mem [DEPTH];

  logic [1:0]    state_q, state_d;
  logic [AW:0]   rcnt_q, rcnt_d;
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW-1:0] dptr_q, dptr_d;
  logic          first_q, first_d;
  logic          last_q, last_d;
  logic [W-1:0]  dout_q, dout_d;
  logic [W-1:0]  odout_q, odout_d;
  logic          oval_q, oval_d;
  logic          pdone_q, pdone_d;
  logic          dpend_q, dpend_d;
  logic          odone_q, odone_d;
  logic          err_q, err_d;

  logic in_acc, in_drn;
  logic rd_exh, rd_ok, wr_ok, ord_ok;
  logic wr_ahead, wr_last, drn_last;

  always_comb begin
    in_acc   = (state_q == S_ACCUM);
    in_drn   = (state_q == S_DRAIN);
    // rcnt MSB marks that all DEPTH reads of this pass were issued
    rd_exh   = rcnt_q[AW];
    rd_ok    = in_acc && psum_mem_rd && !rd_exh;
    wr_ok    = in_acc && psum_mem_wr;
    ord_ok   = in_drn && out_rd;
    wr_ahead = wr_ok && !rd_ok && !rd_exh
               && (wptr_q == rcnt_q[AW-1:0]);
    wr_last  = wr_ok && (wptr_q == '1);
    drn_last = ord_ok && (dptr_q == '1);
  end

  always_comb begin
    state_d = state_q;
    rcnt_d  = rcnt_q;
    wptr_d  = wptr_q;
    dptr_d  = dptr_q;
    first_d = first_q;
    last_d  = last_q;
    dout_d  = dout_q;
    odout_d = odout_q;
    oval_d  = 1'b0;
    pdone_d = 1'b0;
    dpend_d = 1'b0;
    odone_d = dpend_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_ACCUM;
          rcnt_d  = '0;
          wptr_d  = '0;
          first_d = first_pass;
          last_d  = last_pass;
        end
      end
      S_ACCUM: begin
        if (wr_last) begin
          if (last_q) begin
            state_d = S_DRAIN;
            dptr_d  = '0;
          end else begin
            state_d = S_IDLE;
            pdone_d = 1'b1;
          end
        end
      end
      S_DRAIN: begin
        if (drn_last) begin
          state_d = S_IDLE;
          dpend_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (rd_ok) begin
      rcnt_d = rcnt_q + 1'b1;
      dout_d = first_q ? '0 : mem[rcnt_q[AW-1:0]];
    end
    if (wr_ok) wptr_d = wptr_q + 1'b1;
    if (ord_ok) begin
      dptr_d  = dptr_q + 1'b1;
      odout_d = mem[dptr_q];
      oval_d  = 1'b1;
    end

    err_d = err_q
          | (psum_mem_rd && !in_acc)
          | (psum_mem_wr && !in_acc)
          | (out_rd && !in_drn)
          | (psum_mem_rd && in_acc && rd_exh)
          | wr_ahead;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      rcnt_q  <= '0;
      wptr_q  <= '0;
      dptr_q  <= '0;
      first_q <= 1'b0;
      last_q  <= 1'b0;
      dout_q  <= '0;
      odout_q <= '0;
      oval_q  <= 1'b0;
      pdone_q <= 1'b0;
      dpend_q <= 1'b0;
      odone_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      rcnt_q  <= rcnt_d;
      wptr_q  <= wptr_d;
      dptr_q  <= dptr_d;
      first_q <= first_d;
      last_q  <= last_d;
      dout_q  <= dout_d;
      odout_q <= odout_d;
      oval_q  <= oval_d;
      pdone_q <= pdone_d;
      dpend_q <= dpend_d;
      odone_q <= odone_d;
      err_q   <= err_d;
    end
  end

  // Storage is intentionally left out of reset
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wptr_q] <= psum_mem_din;
  end

  assign psum_mem_dout = dout_q;
  assign out_dout      = odout_q;
  assign out_valid     = oval_q;
  assign pass_done     = pdone_q;
  assign out_done      = odone_q;
  assign busy          = (state_q != S_IDLE);
  assign err           = err_q;

endmodule

// File: tb/tb_psum_buffer.sv
// Directed bench for psum_buffer: queue scoreboard on SFU reads
// and drain reads, checked with immediate assertions.
module tb_psum_buffer;

  localparam int W = 128;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic         start = 1'b0;
  logic         first_pass = 1'b0;
  logic         last_pass = 1'b0;
  logic         psum_mem_rd = 1'b0;
  logic         psum_mem_wr = 1'b0;
  logic [W-1:0] psum_mem_din = '0;
  logic [W-1:0] psum_mem_dout;
  logic         out_rd = 1'b0;
  logic [W-1:0] out_dout;
  logic         out_valid;
  logic         pass_done;
  logic         out_done;
  logic         busy;
  logic         err;

  psum_buffer dut (
    .clk(clk),
    .reset(reset),
    .start(start),
    .first_pass(first_pass),
    .last_pass(last_pass),
    .psum_mem_rd(psum_mem_rd),
    .psum_mem_wr(psum_mem_wr),
    .psum_mem_din(psum_mem_din),
    .psum_mem_dout(psum_mem_dout),
    .out_rd(out_rd),
    .out_dout(out_dout),
    .out_valid(out_valid),
    .pass_done(pass_done),
    .out_done(out_done),
    .busy(busy),
    .err(err)
  );

  always #5 clk = ~clk;

  int ncmp = 0;
  int nerr = 0;
  int mdl [64];
  logic [W-1:0] dq [$];
  logic [W-1:0] oq [$];

  function automatic logic [W-1:0] word(input int v);
    logic [15:0] h;
    h = v[15:0];
    return {8{h}};
  endfunction

  task automatic chk(input string tag, input logic [W-1:0] obs,
                     input logic [W-1:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic r, input logic w, input logic o,
                      input logic [W-1:0] d);
    logic [W-1:0] e;
    psum_mem_rd  = r;
    psum_mem_wr  = w;
    out_rd       = o;
    psum_mem_din = d;
    @(posedge clk);
    #1;
    if (r && dq.size() > 0) begin
      e = dq.pop_front();
      chk("dout", psum_mem_dout, e);
    end
    if (oq.size() > 0) begin
      e = oq.pop_front();
      chk("out_valid", W'(out_valid), W'(1));
      chk("out_dout", out_dout, e);
    end else begin
      chk("out_valid_idle", W'(out_valid), W'(0));
    end
    psum_mem_rd = 1'b0;
    psum_mem_wr = 1'b0;
    out_rd      = 1'b0;
  endtask

  task automatic go(input logic fp, input logic lp);
    start      = 1'b1;
    first_pass = fp;
    last_pass  = lp;
    @(posedge clk);
    #1;
    start = 1'b0;
    chk("busy_after_start", W'(busy), W'(1));
  endtask

  task automatic drain_all(input string tag);
    for (int k = 0; k < 64; k++) begin
      oq.push_back(word(mdl[k]));
      step(1'b0, 1'b0, 1'b1, '0);
      if (k < 63) chk({tag, "_busy"}, W'(busy), W'(1));
      chk({tag, "_odone_lo"}, W'(out_done), W'(0));
    end
    chk({tag, "_idle"}, W'(busy), W'(0));
    step(1'b0, 1'b0, 1'b0, '0);
    chk({tag, "_odone"}, W'(out_done), W'(1));
    step(1'b0, 1'b0, 1'b0, '0);
    chk({tag, "_odone_pulse"}, W'(out_done), W'(0));
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    #12;
    chk("rst_dout", psum_mem_dout, '0);
    chk("rst_odout", out_dout, '0);
    chk("rst_oval", W'(out_valid), W'(0));
    chk("rst_pdone", W'(pass_done), W'(0));
    chk("rst_odone", W'(out_done), W'(0));
    chk("rst_busy", W'(busy), W'(0));
    chk("rst_err", W'(err), W'(0));
    reset = 1'b1;
    @(posedge clk);
    #1;

    // first pass: reads return zero
    go(1'b1, 1'b0);
    for (int k = 0; k < 64; k++) begin
      dq.push_back('0);
      step(1'b1, 1'b1, 1'b0, word(k));
      mdl[k] = k;
      chk("p1_pdone", W'(pass_done), W'(k == 63));
    end
    chk("p1_idle", W'(busy), W'(0));
    step(1'b0, 1'b0, 1'b0, '0);
    chk("p1_pdone_pulse", W'(pass_done), W'(0));
    chk("p1_dout_hold", psum_mem_dout, '0);

    // last pass, same-cycle rd/wr: reads see pre-write data
    go(1'b0, 1'b1);
    for (int k = 0; k < 64; k++) begin
      dq.push_back(word(mdl[k]));
      step(1'b1, 1'b1, 1'b0, word(mdl[k] + 1));
      mdl[k] = mdl[k] + 1;
      chk("p2_pdone", W'(pass_done), W'(0));
    end
    chk("p2_drain_busy", W'(busy), W'(1));
    chk("p2_err", W'(err), W'(0));
    step(1'b0, 1'b0, 1'b0, '0);
    chk("p2_dout_hold", psum_mem_dout, word(63));

    // drain with a start pulse that must be ignored
    for (int k = 0; k < 64; k++) begin
      oq.push_back(word(mdl[k]));
      if (k == 10) begin
        start      = 1'b1;
        first_pass = 1'b1;
        last_pass  = 1'b0;
      end
      step(1'b0, 1'b0, 1'b1, '0);
      start = 1'b0;
      if (k < 63) chk("d1_busy", W'(busy), W'(1));
      chk("d1_odone_lo", W'(out_done), W'(0));
    end
    chk("d1_idle", W'(busy), W'(0));
    step(1'b0, 1'b0, 1'b0, '0);
    chk("d1_odone", W'(out_done), W'(1));
    step(1'b0, 1'b0, 1'b0, '0);
    chk("d1_odone_pulse", W'(out_done), W'(0));
    chk("d1_err", W'(err), W'(0));

    // async reset at write 30 of a pass
    go(1'b0, 1'b0);
    for (int k = 0; k < 30; k++) begin
      dq.push_back(word(mdl[k]));
      step(1'b1, 1'b1, 1'b0, word(k + 100));
      mdl[k] = k + 100;
    end
    psum_mem_rd  = 1'b1;
    psum_mem_wr  = 1'b1;
    psum_mem_din = word(999);
    #3;
    reset = 1'b0;
    #1;
    chk("ar_dout", psum_mem_dout, '0);
    chk("ar_busy", W'(busy), W'(0));
    chk("ar_err", W'(err), W'(0));
    @(posedge clk);
    #1;
    psum_mem_rd = 1'b0;
    psum_mem_wr = 1'b0;
    #2;
    reset = 1'b1;
    @(posedge clk);
    #1;

    go(1'b0, 1'b1);
    for (int k = 0; k < 64; k++) begin
      dq.push_back(word(mdl[k]));
      step(1'b1, 1'b1, 1'b0, word(k + 200));
      mdl[k] = k + 200;
    end
    chk("p3_drain_busy", W'(busy), W'(1));
    drain_all("d2");
    chk("d2_err", W'(err), W'(0));

    // protocol errors: sticky, requests ignored
    step(1'b0, 1'b1, 1'b0, word(16'hdead));
    chk("e_idle_wr", W'(err), W'(1));
    go(1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b1, '0);
    chk("e_acc_ord", W'(err), W'(1));
    for (int k = 0; k < 64; k++) begin
      dq.push_back(word(mdl[k]));
      step(1'b1, 1'b0, 1'b0, '0);
    end
    dq.push_back(word(mdl[63]));
    step(1'b1, 1'b0, 1'b0, '0);
    chk("e_rd65_busy", W'(busy), W'(1));
    for (int k = 0; k < 64; k++) begin
      step(1'b0, 1'b1, 1'b0, word(k + 300));
      chk("e_pdone", W'(pass_done), W'(k == 63));
    end
    chk("e_idle", W'(busy), W'(0));
    chk("e_sticky", W'(err), W'(1));
    step(1'b0, 1'b0, 1'b0, '0);
    chk("e_sticky2", W'(err), W'(1));
    chk("dq_empty", W'(dq.size()), W'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
    $finish;
  end

endmodule
